// File: rtl/bmp_cmd_queue_if.sv
// CPU data-bus bundle for the bitmap placer command queue.
// The CPU side drives the master modport; the queue is the slave.
interface bmp_cmd_queue_if;
  logic [15:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output rd_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  rd_en,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/bmp_cmd_queue.sv
// Memory-mapped command FIFO in front of the bitmap/font placer.
// Commands are dispatched one per placer-idle window.
module bmp_cmd_queue #(
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = 4,
  parameter logic [15:0] BASE_ADDR = 16'hC008
) (
  input  logic               clk,
  input  logic               rst_n,
  bmp_cmd_queue_if.slave     bus,
  input  logic               plc_busy,
  output logic [13:0]        ctrl,
  output logic [9:0]         xloc,
  output logic [8:0]         yloc
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GUARD,
    WAIT
  } state_t;

  typedef struct packed {
    logic [13:0] c;
    logic [9:0]  x;
    logic [8:0]  y;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             fresh;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [9:0]         shadow_x;
  logic [8:0]         shadow_y;
  logic               overflow;
  state_t             state;

  logic               hit_ctrl;
  logic               hit_x;
  logic               hit_y;
  logic               hit_st;
  logic               act;
  logic               push_req;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               q_busy;
  logic [15:0]        status;
  logic               unused_ok;

  assign hit_ctrl = bus.wr_en
                  && (bus.addr == BASE_ADDR);
  assign hit_x    = bus.wr_en
                  && (bus.addr == BASE_ADDR + 16'd1);
  assign hit_y    = bus.wr_en
                  && (bus.addr == BASE_ADDR + 16'd2);
  assign hit_st   = bus.rd_en
                  && (bus.addr == BASE_ADDR + 16'd3);

  assign act      = bus.wdata[13]
                  | bus.wdata[6]
                  | bus.wdata[5];
  assign push_req = hit_ctrl && act;

  assign full     = (count == CNT_W'(DEPTH));
  assign pop      = (state == IDLE)
                  && (count != '0)
                  && !plc_busy;

  // A pop frees a slot at the same edge, so a full queue still accepts.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign head     = mem[rd_ptr];
  assign fresh    = '{c: bus.wdata[13:0],
                      x: shadow_x,
                      y: shadow_y};

  assign q_busy   = (count != '0) || (state != IDLE);

  always_comb begin
    status              = '0;
    status[15]          = overflow;
    status[14]          = q_busy;
    status[CNT_W-1:0]   = count;
  end

  assign bus.rdata = hit_st ? status : 16'h0000;
  assign unused_ok = ^bus.wdata[15:14];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= fresh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shadow_x <= '0;
      shadow_y <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (hit_x)
        shadow_x <= bus.wdata[9:0];
      if (hit_y)
        shadow_y <= bus.wdata[8:0];
      if (drop)
        overflow <= 1'b1;
      else if (hit_st)
        overflow <= 1'b0;
    end
  end

  // GUARD covers the cycle before the placer's busy flag can rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctrl  <= '0;
      xloc  <= '0;
      yloc  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            ctrl  <= head.c;
            xloc  <= head.x;
            yloc  <= head.y;
            state <= PULSE;
          end
        end
        PULSE: begin
          ctrl  <= '0;
          state <= GUARD;
        end
        GUARD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!plc_busy)
            state <= IDLE;
        end
        default: begin
          ctrl  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_cmd_queue.sv
// Self-checking bench for bmp_cmd_queue: vector table,
// directed corner sequences and a randomized model comparison.
module tb_bmp_cmd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        plc_busy = 1'b0;
  logic [13:0] ctrl;
  logic [9:0]  xloc;
  logic [8:0]  yloc;

  always #5 clk = ~clk;

  bmp_cmd_queue_if bus ();

  bmp_cmd_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .plc_busy (plc_busy),
    .ctrl     (ctrl),
    .xloc     (xloc),
    .yloc     (yloc)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string nm,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
  endtask

  typedef struct {
    logic [13:0] c;
    logic [9:0]  x;
    logic [8:0]  y;
  } ent_t;

  // Reference model: a plain queue plus a dispatcher-ready flag.
  ent_t        mq[$];
  logic [9:0]  msx;
  logic [8:0]  msy;
  bit          movf;
  bit          mfree;
  int          mage;
  logic [13:0] mctrl;
  logic [9:0]  mx;
  logic [8:0]  my;

  function automatic void m_reset();
    mq.delete();
    msx = '0; msy = '0;
    movf = 0; mfree = 1; mage = 0;
    mctrl = '0; mx = '0; my = '0;
  endfunction

  function automatic logic [15:0] m_rdata();
    logic [15:0] r;
    r = 16'h0000;
    if (bus.rd_en && bus.addr == 16'hC00B) begin
      r[15] = movf;
      r[14] = (mq.size() != 0) || !mfree;
      r[3:0] = 4'(mq.size());
    end
    return r;
  endfunction

  function automatic void m_step();
    bit   pop, creq, drop, st;
    int   sz0;
    ent_t h;
    sz0  = mq.size();
    pop  = mfree && sz0 > 0 && !plc_busy;
    creq = bus.wr_en && bus.addr == 16'hC008
         && (bus.wdata[13] || bus.wdata[6]
             || bus.wdata[5]);
    st   = bus.rd_en && bus.addr == 16'hC00B;
    if (pop) begin
      h = mq.pop_front();
      mctrl = h.c; mx = h.x; my = h.y;
      mfree = 0; mage = 0;
    end else begin
      mctrl = '0;
      if (!mfree) begin
        if (mage >= 2 && !plc_busy) mfree = 1;
        mage++;
      end
    end
    drop = creq && sz0 >= 8 && !pop;
    if (creq && !drop)
      mq.push_back('{bus.wdata[13:0], msx, msy});
    if (drop) movf = 1;
    else if (st) movf = 0;
    if (bus.wr_en && bus.addr == 16'hC009)
      msx = bus.wdata[9:0];
    if (bus.wr_en && bus.addr == 16'hC00A)
      msy = bus.wdata[8:0];
  endfunction

  // Simple placer: busy for three cycles after each pulse.
  bit   auto_plc = 0;
  int   bcnt = 0;
  bit   hi_seen = 0;
  ent_t pl[$];

  task automatic bus_idle();
    bus.addr = 16'h0000; bus.wr_en = 1'b0;
    bus.rd_en = 1'b0; bus.wdata = 16'h0000;
  endtask

  task automatic sample();
    #1;
    check("model_ctrl", ctrl, mctrl);
    check("model_xloc", xloc, mx);
    check("model_yloc", yloc, my);
    check("model_rdata", bus.rdata, m_rdata());
    if (ctrl != '0) begin
      pl.push_back('{ctrl, xloc, yloc});
      if (auto_plc && pl.size() > 1)
        check("busy_before_pulse", hi_seen, 1);
      hi_seen = 0;
      if (auto_plc) bcnt = 3;
    end
    if (plc_busy) hi_seen = 1;
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    @(negedge clk);
    if (auto_plc) begin
      plc_busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
    end
  endtask

  task automatic tick();
    sample();
    step();
  endtask

  task automatic wr(logic [15:0] a, logic [15:0] d);
    bus.addr = a; bus.wr_en = 1'b1; bus.wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic rd_chk(string nm, logic [15:0] exp);
    bus.addr = 16'hC00B; bus.rd_en = 1'b1;
    sample();
    check(nm, bus.rdata, exp);
    step();
    bus_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    auto_plc = 0; bcnt = 0; plc_busy = 1'b0;
    m_reset();
    #1;
    check("rst_ctrl", ctrl, 0);
    check("rst_xloc", xloc, 0);
    check("rst_yloc", yloc, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    bit          rd;
    logic [15:0] wdata;
    logic [13:0] ectrl;
    logic [9:0]  ex;
    logic [8:0]  ey;
    logic [15:0] erd;
  } vec_t;

  vec_t tv[11];

  initial begin
    bus_idle();
    m_reset();
    tv[0]  = '{16'hC009, 1, 0, 16'd100,  0, 0, 0, 0};
    tv[1]  = '{16'hC00A, 1, 0, 16'd50,   0, 0, 0, 0};
    tv[2]  = '{16'hC008, 1, 0, 16'h0041, 0, 0, 0, 0};
    tv[3]  = '{16'hC00B, 0, 1, 0, 0, 0, 0, 16'h4001};
    tv[4]  = '{16'hC00B, 0, 1, 0, 14'h0041, 100, 50,
               16'h4000};
    tv[5]  = '{16'hC00B, 0, 1, 0, 0, 100, 50, 16'h4000};
    tv[6]  = '{16'hC00B, 0, 1, 0, 0, 100, 50, 16'h4000};
    tv[7]  = '{16'hC00B, 0, 1, 0, 0, 100, 50, 16'h0000};
    tv[8]  = '{16'hC008, 1, 0, 16'h0003, 0, 100, 50, 0};
    tv[9]  = '{16'hC00B, 0, 1, 0, 0, 100, 50, 16'h0000};
    tv[10] = '{16'hC00A, 0, 1, 0, 0, 100, 50, 16'h0000};

    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      bus.addr = tv[i].addr; bus.wr_en = tv[i].wr;
      bus.rd_en = tv[i].rd; bus.wdata = tv[i].wdata;
      sample();
      check($sformatf("vec%0d_ctrl", i), ctrl, tv[i].ectrl);
      check($sformatf("vec%0d_xloc", i), xloc, tv[i].ex);
      check($sformatf("vec%0d_yloc", i), yloc, tv[i].ey);
      check($sformatf("vec%0d_rdata", i), bus.rdata,
            tv[i].erd);
      step();
    end
    bus_idle();

    // Three font commands queued while the placer is busy.
    pl.delete();
    plc_busy = 1'b1;
    wr(16'hC009, 16'd0);  wr(16'hC008, 16'h2080);
    wr(16'hC009, 16'd13); wr(16'hC008, 16'h2100);
    wr(16'hC009, 16'd26); wr(16'hC008, 16'h2180);
    tick(); tick();
    check("t2_no_pulse_busy", pl.size(), 0);
    rd_chk("t2_status", 16'h4003);
    hi_seen = 0; auto_plc = 1; plc_busy = 1'b0;
    for (int i = 0; i < 60 && pl.size() < 3; i++) tick();
    check("t2_npulse", pl.size(), 3);
    if (pl.size() == 3) begin
      check("t2_c0", pl[0].c, 14'h2080);
      check("t2_c1", pl[1].c, 14'h2100);
      check("t2_c2", pl[2].c, 14'h2180);
      check("t2_x0", pl[0].x, 0);
      check("t2_x1", pl[1].x, 13);
      check("t2_x2", pl[2].x, 26);
      check("t2_y2", pl[2].y, 50);
    end
    repeat (8) tick();

    // Overflow: nine pushes into an eight-entry queue.
    do_reset();
    plc_busy = 1'b1;
    for (int i = 0; i < 9; i++)
      wr(16'hC008, 16'h0020 + 16'(i));
    rd_chk("t3_status_ovf", 16'hC008);
    rd_chk("t3_status_clr", 16'h4008);
    pl.delete(); hi_seen = 0;
    auto_plc = 1; plc_busy = 1'b0;
    for (int i = 0; i < 200 && pl.size() < 8; i++) tick();
    repeat (10) tick();
    check("t3_npulse", pl.size(), 8);
    if (pl.size() == 8) begin
      check("t3_first", pl[0].c, 14'h0020);
      check("t3_last", pl[7].c, 14'h0027);
    end
    rd_chk("t3_drained", 16'h0000);

    // Push into a full queue on the pop edge.
    do_reset();
    plc_busy = 1'b1;
    for (int i = 0; i < 8; i++)
      wr(16'hC008, 16'h0040 + 16'(i));
    rd_chk("t5_full", 16'h4008);
    pl.delete();
    plc_busy = 1'b0;
    wr(16'hC008, 16'h0060);
    plc_busy = 1'b1;
    rd_chk("t5_same_edge", 16'h4008);
    check("t5_pulse", pl.size(), 1);
    hi_seen = 1; auto_plc = 1; plc_busy = 1'b0;
    for (int i = 0; i < 200 && pl.size() < 9; i++) tick();
    repeat (8) tick();
    check("t5_npulse", pl.size(), 9);
    if (pl.size() == 9) begin
      check("t5_first", pl[0].c, 14'h0040);
      check("t5_last", pl[8].c, 14'h0060);
    end

    // Reset while the dispatcher waits on the placer.
    do_reset();
    wr(16'hC009, 16'd5);
    wr(16'hC00A, 16'd7);
    plc_busy = 1'b1;
    for (int i = 0; i < 5; i++)
      wr(16'hC008, 16'h2000 + 16'(i));
    pl.delete();
    auto_plc = 1; plc_busy = 1'b0;
    for (int i = 0; i < 20 && pl.size() < 1; i++) tick();
    check("t6_first_pulse", pl.size(), 1);
    tick();
    check("t6_xloc_held", xloc, 5);
    rd_chk("t6_pre_status", 16'h4004);
    do_reset();
    rd_chk("t6_post_status", 16'h0000);
    pl.delete();
    repeat (12) tick();
    check("t6_no_pulse", pl.size(), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int p, sel;
      if (i == 1500) begin
        bus_idle();
        do_reset();
      end
      if (i % 16 == 0) p = $urandom_range(0, 4);
      plc_busy = ($urandom_range(0, 3) < p);
      sel = $urandom_range(0, 4);
      bus.addr = (sel < 4) ? 16'hC008 + 16'(sel)
                           : 16'($urandom);
      bus.wr_en = $urandom_range(0, 1) == 1;
      bus.rd_en = $urandom_range(0, 2) == 0;
      bus.wdata = 16'($urandom);
      tick();
    end
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
